// File: rtl/ram_stream_fifo.sv
// ram_stream_fifo
// Streaming FIFO controller in front of a dual-port RAM with a one-cycle
// registered read. Incoming words are written straight into the RAM. Words
// are prefetched into a 2-entry output queue (q0 = head, q1 = second) so the
// output can sustain one word per cycle despite the read latency.
//
// Handshake semantics (both streams): a transfer ("fire") happens in a cycle
// where valid and ready are both high at the rising edge. A producer holds
// valid and data stable until the fire. ready never depends on valid on the
// same side: in_ready comes from registered state only.
module ram_stream_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_ren,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH+1:0] count
);

    // ram_cnt must reach DEPTH, so it needs one bit more than an address.
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Registered state
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         ram_cnt;
    logic                  rd_pend;   // a RAM read returns data this cycle
    logic [1:0]            held;      // valid entries in q0/q1
    logic [DATA_WIDTH-1:0] q0;
    logic [DATA_WIDTH-1:0] q1;

    // Per-cycle events
    logic                  in_fire;
    logic                  out_fire;
    logic                  rd_issue;
    logic [1:0]            occ;       // queue slots held or already claimed
    logic [1:0]            slot;      // slot the returning word lands in

    // Handshake outputs and fire detection
    always_comb begin
        in_ready  = rst_n & (ram_cnt != FULL_CNT);
        in_fire   = in_valid & in_ready;
        out_valid = (held != 2'd0);
        out_data  = q0;
        out_fire  = out_valid & out_ready;
    end

    // Read issue: claim a queue slot only if one is free now, or one is
    // being freed by this cycle's output transfer. Gated by reset so no
    // read leaves the block while rst_n is low.
    always_comb begin
        occ      = held + {1'b0, rd_pend};
        rd_issue = rst_n & (ram_cnt != '0) &
                   ((occ < 2'd2) | ((occ == 2'd2) & out_fire));
        slot     = held - {1'b0, out_fire};
    end

    // RAM port drive: write and read address come straight from the pointers
    always_comb begin
        ram_wen   = in_fire;
        ram_waddr = wptr;
        ram_din   = in_data;
        ram_ren   = rd_issue;
        ram_raddr = rptr;
    end

    // Occupancy reported to the outside: RAM + in-flight read + queue
    always_comb begin
        count = TW'(ram_cnt) + TW'(rd_pend) + TW'(held);
    end

    // Pointers and RAM occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
        end else begin
            if (in_fire) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_issue) begin
                rptr <= rptr + 1'b1;
            end
            ram_cnt <= ram_cnt + CW'(in_fire) - CW'(rd_issue);
        end
    end

    // In-flight read tracking; reset drops any read still returning
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
        end
    end

    // Output queue: shift on output transfer, then capture the returning
    // word into the first slot that is free after that shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held <= 2'd0;
            q0   <= '0;
            q1   <= '0;
        end else begin
            held <= held + {1'b0, rd_pend} - {1'b0, out_fire};
            if (out_fire) begin
                q0 <= q1;
            end
            if (rd_pend) begin
                if (slot == 2'd0) begin
                    q0 <= ram_dout;
                end else begin
                    q1 <= ram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Testbench for ram_stream_fifo: directed scenarios plus randomized
// valid/ready traffic, scored against a queue-based reference of the FIFO.
module tb_ram_stream_fifo;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;
    logic          ram_wen;
    logic [AW-1:0] ram_raddr;
    logic          ram_ren;
    logic [DW-1:0] ram_dout;
    logic [AW+1:0] count;

    ram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_wen(ram_wen),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_dout(ram_dout),
        .count(count)
    );

    // Dual-port RAM with registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_din;
        if (ram_ren) ram_dout <= mem[ram_raddr];
    end

    // ---------------- scoreboard / reference ----------------
    logic [DW-1:0] exp_q[$];
    int mcount = 0;          // words accepted and not yet delivered
    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    logic s_in_fire, s_out_fire;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs after the falling edge, sample 1ns later,
    // check invariants against the reference, then advance the reference.
    task automatic step(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(negedge clk);
        rst_n = r; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        cyc++;
        s_in_fire  = in_valid & in_ready;
        s_out_fire = out_valid & out_ready;
        check("count", 64'(count), 64'(mcount));
        if (mcount == 0) check("empty_out_valid", 64'(out_valid), 64'd0);
        if (mcount == DEPTH + 2) check("full_in_ready", 64'(in_ready), 64'd0);
        check("wen_is_fire", 64'(ram_wen), 64'(s_in_fire));
        if (ram_wen) check("ram_din", 64'(ram_din), 64'(in_data));
        if (ram_wen & ram_ren) check("addr_collide", 64'(ram_waddr != ram_raddr), 64'd1);
        if (!rst_n) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            if (s_out_fire) begin
                if (exp_q.size() > 0) check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                else check("underflow", 64'd1, 64'd0);
                mcount--;
            end
            if (s_in_fire) begin
                exp_q.push_back(in_data);
                mcount++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (mcount > 0 && n < budget) begin
            step(1'b1, 1'b0, '0, 1'b1);
            n++;
        end
        if (mcount > 0) check("drain_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sent, got, first_in, first_out, n;
        logic          pend_v;
        logic [DW-1:0] pend_d;

        rst_n = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
        @(posedge clk);

        // Reset held 3 cycles with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'hDEAD_0000 + i, 1'b1);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_wen", 64'(ram_wen), 64'd0);
            check("rst_ren", 64'(ram_ren), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_count", 64'(count), 64'd0);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_data", 64'(out_data), 64'd0);

        // Single word latency
        step(1'b1, 1'b1, 32'hA5A5_0001, 1'b1);
        check("single_wen", 64'(ram_wen), 64'd1);
        check("single_waddr", 64'(ram_waddr), 64'd0);
        step(1'b1, 1'b0, '0, 1'b1);
        check("single_ren", 64'(ram_ren), 64'd1);
        check("single_raddr", 64'(ram_raddr), 64'd0);
        step(1'b1, 1'b0, '0, 1'b1);
        check("single_c2_valid", 64'(out_valid), 64'd0);
        step(1'b1, 1'b0, '0, 1'b1);
        check("single_c3_valid", 64'(out_valid), 64'd1);
        check("single_c3_data", 64'(out_data), 64'hA5A5_0001);
        step(1'b1, 1'b0, '0, 1'b1);
        check("single_count_zero", 64'(count), 64'd0);

        // Streaming 40 words with no gaps after the 3-cycle latency
        sent = 0; got = 0; first_in = -1; first_out = -1; n = 0;
        while (got < 40 && n < 200) begin
            step(1'b1, sent < 40, DW'(sent), 1'b1);
            if (s_in_fire) begin
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (first_out >= 0) check("stream_no_gap", 64'(s_out_fire), 64'd1);
            if (s_out_fire) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    check("stream_latency", 64'(first_out - first_in), 64'd3);
                end
                got++;
            end
            n++;
        end
        if (got < 40) check("stream_timeout", 64'd0, 64'd1);

        // Fill with output stalled, then drain
        sent = 0; n = 0;
        while (sent < DEPTH + 2 && n < 100) begin
            step(1'b1, 1'b1, 32'hF000_0000 + sent, 1'b0);
            if (s_in_fire) sent++;
            n++;
        end
        step(1'b1, 1'b1, 32'hBAD0_0000, 1'b0);
        check("fill_count", 64'(count), 64'(DEPTH + 2));
        check("fill_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        step(1'b1, 1'b0, '0, 1'b1);
        check("fill_first_issue", 64'(ram_ren), 64'd1);
        check("fill_still_full", 64'(in_ready), 64'd0);
        step(1'b1, 1'b0, '0, 1'b1);
        check("fill_reopen", 64'(in_ready), 64'd1);
        drain(100);

        // Random traffic, in_valid held until fire
        pend_v = 1'b0; pend_d = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!pend_v && $urandom_range(0, 3) != 0) begin
                pend_v = 1'b1;
                pend_d = $urandom;
            end
            step(1'b1, pend_v, pend_d, $urandom_range(0, 2) != 0);
            if (s_in_fire) pend_v = 1'b0;
        end
        drain(100);
        check("random_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream while a read is in flight
        sent = 0; n = 0;
        while (sent < DEPTH + 2 && n < 100) begin
            step(1'b1, 1'b1, 32'hC000_0000 + sent, 1'b0);
            if (s_in_fire) sent++;
            n++;
        end
        step(1'b1, 1'b0, '0, 1'b1);
        check("mid_issue", 64'(ram_ren), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("mid_count", 64'(count), 64'd0);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0);
        got = 0; n = 0;
        while (got == 0 && n < 20) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (s_out_fire) begin
                check("mid_first_word", 64'(out_data), 64'h1234_5678);
                got = 1;
            end
            n++;
        end
        if (got == 0) check("mid_timeout", 64'd0, 64'd1);
        step(1'b1, 1'b0, '0, 1'b1);
        check("mid_final_count", 64'(count), 64'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
